seq_restoring_div: RTL and testbench

Parametrised, multi-cycle radix-2 restoring divider. It replaces the single-cycle combinational divider with a one-iteration-per-cycle datapath and a start/busy/done handshake. This bounds the critical path to one WIDTH+1-bit subtract. The block sits behind the ALU issue logic and serves one division at a time. It adds divide-by-zero reporting and an optional signed mode.

---
 rtl/seq_restoring_div.sv | 194 +++++++++++++++++++
 tb/tb_seq_restoring_div.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_div.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_div
//  Purpose  : Multi-cycle radix-2 restoring divider, one quotient bit per
//             clock, with a start/busy/done handshake and divide-by-zero
//             reporting. Serves one division at a time.
//  Ports    : clk          rising-edge clock
//             reset        asynchronous, active-low reset
//             start        request, sampled on a rising edge while busy=0
//             dividend     numerator, captured on the accepting edge
//             divisor      denominator, captured on the accepting edge
//             signed_mode  two's-complement operands (DIV_SIGNED_EN only)
//             busy         a division is in progress
//             done         one-cycle pulse, results valid from this cycle
//             quotient     registered quotient
//             remainder    registered remainder
//             div_by_zero  last completed operation had divisor=0
//  Config   : define DIV_SIGNED_EN to add the signed_mode port and the
//             truncate-toward-zero signed fix-up.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               C_CNT_W = $clog2(WIDTH + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
   localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_ZERO = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   // The stored partial remainder is always below the divisor after a step,
   // so it fits in WIDTH bits; the extra bit lives on the shifted value.
   logic [WIDTH-1:0]    p_q, p_d;
   logic [WIDTH-1:0]    a_q, a_d;
   logic [WIDTH-1:0]    dvs_q, dvs_d;
   logic [C_CNT_W-1:0]  cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [WIDTH-1:0]    quot_q, quot_d;
   logic [WIDTH-1:0]    rem_q, rem_d;
   logic                dbz_q, dbz_d;
   logic                qneg_q, qneg_d;
   logic                rneg_q, rneg_d;

   logic [WIDTH:0]      w_p_shift;
   logic [WIDTH:0]      w_trial;
   logic [WIDTH-1:0]    w_dvd_mag;
   logic [WIDTH-1:0]    w_dvs_mag;
   logic                w_dvd_neg;
   logic                w_dvs_neg;

   // One restoring step: shift {P,A} left, trial-subtract the divisor.
   assign w_p_shift = {p_q, a_q[WIDTH-1]};
   assign w_trial   = w_p_shift - {1'b0, dvs_q};

`ifdef DIV_SIGNED_EN
   assign w_dvd_neg = signed_mode & dividend[WIDTH-1];
   assign w_dvs_neg = signed_mode & divisor[WIDTH-1];
`else
   assign w_dvd_neg = 1'b0;
   assign w_dvs_neg = 1'b0;
`endif
   // The most-negative value maps onto itself, which is its correct unsigned
   // magnitude, so no special case is needed.
   assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
   assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      a_d     = a_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (divisor == '0) begin
                  // Raw dividend is kept for the zero-divisor remainder.
                  a_d     = dividend;
                  state_d = S_ZERO;
               end else begin
                  p_d     = '0;
                  a_d     = w_dvd_mag;
                  dvs_d   = w_dvs_mag;
                  cnt_d   = C_CNT_INIT;
                  qneg_d  = w_dvd_neg ^ w_dvs_neg;
                  rneg_d  = w_dvd_neg;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (!w_trial[WIDTH]) begin
               p_d = w_trial[WIDTH-1:0];
               a_d = {a_q[WIDTH-2:0], 1'b1};
            end else begin
               p_d = w_p_shift[WIDTH-1:0];
               a_d = {a_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            quot_d  = qneg_q ? -a_q : a_q;
            rem_d   = rneg_q ? -p_q : p_q;
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ZERO: begin
            quot_d  = '1;
            rem_d   = a_q;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         a_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         a_q     <= a_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_restoring_div
//  Purpose  : Self-checking bench for seq_restoring_div (WIDTH=32). Directed
//             operations push their expected result and completion cycle
//             into a scoreboard; a monitor pops and compares on every done.
//  Config   : signed cases run only when DIV_SIGNED_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_div;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          sm = 1'b0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  quotient, remainder;

   int cyc = 0;
   int n_tot = 0;
   int n_pass = 0;
   logic prev_done = 1'b0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           at;
   } exp_t;
   exp_t sb[$];

   seq_restoring_div #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef DIV_SIGNED_EN
      .signed_mode (sm),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         check("done_width", {63'd0, prev_done}, 64'd0);
         check("busy_in_done", {63'd0, busy}, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", {32'd0, quotient}, {32'd0, e.q});
            check("remainder", {32'd0, remainder}, {32'd0, e.r});
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.z});
            check("latency", 64'(cyc), 64'(e.at));
         end
      end
      prev_done <= done;
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int lat, input bit push);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("busy_timeout", 64'd1, 64'd0);
      dividend = a;
      divisor  = b;
      sm       = s;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.q = eq; e.r = er; e.z = ez; e.at = cyc + lat;
         sb.push_back(e);
      end
   endtask

   // Hold start high from the done cycle; it must be accepted on the very next edge.
   task automatic chain(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("chain_done_seen", {63'd0, done}, 64'd1);
      dividend = a;
      divisor  = b;
      sm       = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("chain_accepted", {63'd0, busy}, 64'd1);
      e.q = eq; e.r = er; e.z = 1'b0; e.at = cyc + W + 1;
      sb.push_back(e);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_quot", {32'd0, quotient}, 64'd0);
      check("rst_rem", {32'd0, remainder}, 64'd0);
      check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      reset = 1'b1;

      // Basic and width corners
      issue(32'd87, 32'd5, 1'b0, 32'd17, 32'd2, 1'b0, W + 1, 1'b1);
      issue(32'd59, 32'd20, 1'b0, 32'd2, 32'd19, 1'b0, W + 1, 1'b1);
      issue(32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, W + 1, 1'b1);
      issue(32'h8000_0000, 32'hC000_0000, 1'b0, 32'd0, 32'h8000_0000, 1'b0, W + 1, 1'b1);
      issue(32'h1234_5678, 32'd1, 1'b0, 32'h1234_5678, 32'd0, 1'b0, W + 1, 1'b1);
      issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd1, 32'd0, 1'b0, W + 1, 1'b1);

      // Divide by zero, then a normal op clears the flag
      issue(32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1, 1'b1);
      issue(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, W + 1, 1'b1);

      // start mid-RUN with other operands must be ignored
      issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, W + 1, 1'b1);
      repeat (5) @(negedge clk);
      dividend = 32'd9; divisor = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Back-to-back through the done cycle
      issue(32'd255, 32'd16, 1'b0, 32'd15, 32'd15, 1'b0, W + 1, 1'b1);
      chain(32'd59, 32'd20, 32'd2, 32'd19);

      // Reset during RUN: outputs clear, no done appears
      issue(32'd87, 32'd5, 1'b0, '0, '0, 1'b0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_done", {63'd0, done}, 64'd0);
      check("mid_rst_quot", {32'd0, quotient}, 64'd0);
      check("mid_rst_rem", {32'd0, remainder}, 64'd0);
      check("mid_rst_dbz", {63'd0, div_by_zero}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      issue(32'd87, 32'd5, 1'b0, 32'd17, 32'd2, 1'b0, W + 1, 1'b1);

`ifdef DIV_SIGNED_EN
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, W + 1, 1'b1);
      issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, W + 1, 1'b1);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, W + 1, 1'b1);
      issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b1);
`endif
      issue(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, W + 1, 1'b1);

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("outstanding", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
